// File: rtl/muldiv_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_alu                                             |
// | Description : Single-issue ALU with iterative shift-add multiplier   |
// |               and restoring divider behind a valid/ready handshake.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module muldiv_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ge,
    output logic            overflow
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [4:0] c_op_add    = 5'd0;
    localparam logic [4:0] c_op_sub    = 5'd1;
    localparam logic [4:0] c_op_and    = 5'd2;
    localparam logic [4:0] c_op_or     = 5'd3;
    localparam logic [4:0] c_op_xor    = 5'd4;
    localparam logic [4:0] c_op_sll    = 5'd5;
    localparam logic [4:0] c_op_srl    = 5'd6;
    localparam logic [4:0] c_op_sra    = 5'd7;
    localparam logic [4:0] c_op_slt    = 5'd8;
    localparam logic [4:0] c_op_sltu   = 5'd9;
    localparam logic [4:0] c_op_lui    = 5'd10;
    localparam logic [4:0] c_op_mulh   = 5'd17;
    localparam logic [4:0] c_op_mulhsu = 5'd18;
    localparam logic [4:0] c_op_div    = 5'd20;
    localparam logic [4:0] c_op_divu   = 5'd21;
    localparam logic [4:0] c_op_rem    = 5'd22;
    localparam logic [4:0] c_op_remu   = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [XLEN-1:0]  r_result;
    logic             r_zero;
    logic             r_lt;
    logic             r_ge;
    logic             r_ovf;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_mcand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [1:0]       r_sel;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_accept;
    logic             w_is_muldiv;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_special;
    logic             w_long;
    logic             w_last;
    logic             w_load;
    logic [XLEN-1:0]  w_res_d;
    logic             w_ovf_d;

    logic [SHW-1:0]   w_shamt;
    logic [XLEN-1:0]  w_sum;
    logic [XLEN-1:0]  w_diff;
    logic             w_slt;
    logic [XLEN-1:0]  w_alu_res;
    logic             w_alu_ovf;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;

    logic [XLEN:0]    w_mul_sum;
    logic [XLEN:0]    w_div_shift;
    logic [XLEN:0]    w_div_trial;
    logic             w_div_ok;
    logic [XLEN-1:0]  w_hi_nx;
    logic [XLEN-1:0]  w_lo_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]  w_quot;
    logic [XLEN-1:0]  w_rem;
    logic [XLEN-1:0]  w_calc_res;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_is_muldiv = (op[4:3] == 2'b10);
    assign w_div_zero  = (b == '0);
    assign w_div_ovf   = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_special   = w_is_muldiv && op[2] &&
                         (w_div_zero || (!op[0] && w_div_ovf));
    assign w_long      = w_is_muldiv && !w_special;
    assign w_last      = (r_cnt == CNT_W'(XLEN-1));

    // Single-cycle results, including the divide special cases.
    assign w_shamt = b[SHW-1:0];
    assign w_sum   = a + b;
    assign w_diff  = a - b;
    assign w_slt   = ($signed(a) < $signed(b));

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (op)
            c_op_add: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[XLEN-1] == b[XLEN-1]) && (w_sum[XLEN-1] != a[XLEN-1]);
            end
            c_op_sub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[XLEN-1] != b[XLEN-1]) && (w_diff[XLEN-1] != a[XLEN-1]);
            end
            c_op_and:  w_alu_res = a & b;
            c_op_or:   w_alu_res = a | b;
            c_op_xor:  w_alu_res = a ^ b;
            c_op_sll:  w_alu_res = a << w_shamt;
            c_op_srl:  w_alu_res = a >> w_shamt;
            c_op_sra:  w_alu_res = $signed(a) >>> w_shamt;
            c_op_slt:  w_alu_res = {{(XLEN-1){1'b0}}, w_slt};
            c_op_sltu: w_alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            c_op_lui:  w_alu_res = b;
            c_op_div:  w_alu_res = w_div_zero ? '1 : a;
            c_op_divu: w_alu_res = '1;
            c_op_rem:  w_alu_res = w_div_zero ? a : '0;
            c_op_remu: w_alu_res = a;
            default:   w_alu_res = '0;
        endcase
    end

    // Signed variants run on magnitudes; the sign is restored on the last step.
    assign w_a_neg = a[XLEN-1] && ((op == c_op_mulh) || (op == c_op_mulhsu) ||
                                   (op == c_op_div)  || (op == c_op_rem));
    assign w_b_neg = b[XLEN-1] && ((op == c_op_mulh) || (op == c_op_div) ||
                                   (op == c_op_rem));
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mcand : {XLEN{1'b0}})};
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_mcand};
    assign w_div_ok    = !w_div_trial[XLEN];

    always_comb begin
        w_hi_nx = w_mul_sum[XLEN:1];
        w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
        if (r_is_div) begin
            w_hi_nx = w_div_ok ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], w_div_ok};
        end
    end

    assign w_prod   = {w_hi_nx, w_lo_nx};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quot   = r_neg_q ? -w_lo_nx : w_lo_nx;
    assign w_rem    = r_neg_r ? -w_hi_nx : w_hi_nx;

    always_comb begin
        w_calc_res = '0;
        if (r_is_div) begin
            w_calc_res = r_sel[1] ? w_rem : w_quot;
        end else if (r_sel == 2'd0) begin
            w_calc_res = w_prod_s[XLEN-1:0];
        end else begin
            w_calc_res = w_prod_s[2*XLEN-1:XLEN];
        end
    end

    assign w_load  = (w_accept && !w_long) || ((r_state == S_CALC) && w_last);
    assign w_res_d = (r_state == S_CALC) ? w_calc_res : w_alu_res;
    assign w_ovf_d = (r_state == S_CALC) ? 1'b0 : w_alu_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nx = w_long ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_lt     <= 1'b0;
            r_ge     <= 1'b1;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sel    <= 2'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            if (w_load) begin
                r_result <= w_res_d;
                r_zero   <= (w_res_d == '0);
                r_lt     <= w_res_d[XLEN-1];
                r_ge     <= !w_res_d[XLEN-1];
                r_ovf    <= w_ovf_d;
            end
            if (w_accept && w_long) begin
                r_hi     <= '0;
                r_lo     <= w_a_mag;
                r_mcand  <= w_b_mag;
                r_cnt    <= '0;
                r_is_div <= op[2];
                r_sel    <= op[1:0];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
            end else if (r_state == S_CALC) begin
                r_hi  <= w_hi_nx;
                r_lo  <= w_lo_nx;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign lt        = r_lt;
    assign ge        = r_ge;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_muldiv_alu                                          |
// | Description : Directed self-checking bench for muldiv_alu (XLEN=32). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_muldiv_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        ge;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    muldiv_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .lt        (lt),
        .ge        (ge),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Issues one request, scrambles the operands after acceptance and
    // returns the result, flags {zero,lt,ge,overflow} and cycles to out_valid.
    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic [3:0] fl, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = ~y; op = 5'd0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        fl  = {zero, lt, ge, overflow};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, result, zero, lt, ge, overflow} !== {1'b1, 1'b0, 32'd0, 4'b1010}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h z/l/g/o=%b%b%b%b want rdy=1 vld=0 res=0 z/l/g/o=1010",
                     in_ready, out_valid, result, zero, lt, ge, overflow);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        logic [4:0]  v_op  [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd9, 5'd10};
        logic [31:0] v_a   [12] = '{32'h7FFFFFFF, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                    32'h00000001, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000001,
                                    32'hFFFFFFFF, 32'h0000ABCD};
        logic [31:0] v_b   [12] = '{32'h00000001, 32'h00000001, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                    32'h00000021, 32'h00000024, 32'h00000024, 32'h00000001, 32'hFFFFFFFF,
                                    32'h00000001, 32'h12345000};
        logic [31:0] v_res [12] = '{32'h80000000, 32'h7FFFFFFF, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                    32'h00000002, 32'h08000000, 32'hF8000000, 32'h00000001, 32'h00000001,
                                    32'h00000000, 32'h12345000};
        logic [3:0]  v_fl  [12] = '{4'b0101, 4'b0011, 4'b0100, 4'b0100, 4'b0010,
                                    4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0010,
                                    4'b1010, 4'b0010};
        for (int i = 0; i < 12; i++) begin
            do_op(v_op[i], v_a[i], v_b[i], res, fl, lat);
            total++;
            if (res !== v_res[i] || fl !== v_fl[i] || lat != 1) begin
                bad++;
                $display("FAIL alu_vec%0d op=%0d: got res=%h fl=%b lat=%0d want res=%h fl=%b lat=1",
                         i, v_op[i], res, fl, lat, v_res[i], v_fl[i]);
            end
        end
        do_op(5'd11, 32'd5, 32'd5, res, fl, lat);
        total++;
        if (res !== 32'd0 || fl !== 4'b1010 || lat != 1) begin
            bad++;
            $display("FAIL reserved_op: got res=%h fl=%b lat=%0d want res=0 fl=1010 lat=1", res, fl, lat);
        end
    endtask

    task automatic test_muldiv();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        logic [4:0]  v_op  [12] = '{5'd19, 5'd16, 5'd17, 5'd17, 5'd18, 5'd16,
                                    5'd20, 5'd22, 5'd21, 5'd23, 5'd20, 5'd22};
        logic [31:0] v_a   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd7,
                                    32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] v_b   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                    32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] v_res [12] = '{32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFEB,
                                    32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        for (int i = 0; i < 12; i++) begin
            do_op(v_op[i], v_a[i], v_b[i], res, fl, lat);
            total++;
            if (res !== v_res[i] || fl[0] !== 1'b0 || lat != 33) begin
                bad++;
                $display("FAIL muldiv_vec%0d op=%0d: got res=%h ovf=%b lat=%0d want res=%h ovf=0 lat=33",
                         i, v_op[i], res, fl[0], lat, v_res[i]);
            end
        end
    endtask

    task automatic test_div_special();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        logic [4:0]  v_op  [5] = '{5'd21, 5'd22, 5'd20, 5'd22, 5'd20};
        logic [31:0] v_a   [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] v_b   [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] v_res [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            do_op(v_op[i], v_a[i], v_b[i], res, fl, lat);
            total++;
            if (res !== v_res[i] || fl[3] !== (v_res[i] == 32'd0) || lat != 1) begin
                bad++;
                $display("FAIL div_special%0d op=%0d: got res=%h zero=%b lat=%0d want res=%h lat=1",
                         i, v_op[i], res, fl[3], lat, v_res[i]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        op = 5'd0; a = 32'd10; b = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd30) begin
                bad++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=0000001e",
                         i, out_valid, in_ready, result);
            end
            a = $urandom; b = $urandom; in_valid = (i % 2 == 0); op = 5'(i + 1);
            @(posedge clk); #1;
        end
        op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd30) begin
            bad++;
            $display("FAIL no_back_to_back: got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=0000001e",
                     out_valid, in_ready, result);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        bit          seen;
        @(negedge clk);
        op = 5'd20; a = 32'd100; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_calc: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0",
                     in_ready, out_valid, result);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL aborted_no_valid: got out_valid seen=%b want 0", seen);
        end
        do_op(5'd0, 32'd2, 32'd3, res, fl, lat);
        total++;
        if (res !== 32'd5 || fl !== 4'b0010 || lat != 1) begin
            bad++;
            $display("FAIL add_after_reset: got res=%h fl=%b lat=%0d want res=5 fl=0010 lat=1", res, fl, lat);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_div_special();
        test_hold();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_alu.md
MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (power of two, 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), meaning shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request (high only in IDLE).
REQ-007 op  input  5  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 LUI, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; others reserved.
REQ-008 a, b  input  XLEN each  operands.
REQ-009 out_valid  output  1  result valid, held until accepted.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  XLEN  registered result.
REQ-012 zero, lt, ge, overflow  output  1 each  registered flags for result.

Function
REQ-013 SHALL implement FSM IDLE -> (CALC) -> DONE -> IDLE; handshake fires when in_valid && in_ready.
REQ-014 Ops 0-10, reserved ops and mul/div special cases SHALL go IDLE -> DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-015 Ops 16-23 (non-special) SHALL go IDLE -> CALC for exactly XLEN cycles, then DONE; out_valid rises XLEN+1 cycles after acceptance.
REQ-016 Operands and op SHALL be captured at acceptance; input changes afterwards have no effect.
REQ-017 In DONE, result/flags/out_valid SHALL stay stable until out_ready; on out_valid && out_ready return to IDLE next cycle; no back-to-back acceptance in that cycle.
REQ-018 ADD/SUB SHALL wrap modulo 2^XLEN; overflow = signed overflow of ADD/SUB, 0 for every other op.
REQ-019 Shifts SHALL use b[SHW-1:0] only; SRA arithmetic, SRL/SLL zero-fill.
REQ-020 SLT/SLTU SHALL produce 1 or 0 (signed / unsigned compare); LUI SHALL pass b.
REQ-021 MUL SHALL return low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of 2*XLEN product (signed*signed, signed*unsigned, unsigned*unsigned); iterative shift-add, one bit per cycle.
REQ-022 DIV/DIVU SHALL return quotient truncated toward zero; REM/REMU remainder with sign of a; restoring division, one bit per cycle.
REQ-023 Divide by zero SHALL return quotient all-ones and remainder = a, latency 1.
REQ-024 Signed DIV/REM of -2^(XLEN-1) by -1 SHALL return quotient = a, remainder 0, latency 1.
REQ-025 Reserved op SHALL return result 0 with zero=1.
REQ-026 zero = (result==0); lt = result[XLEN-1]; ge = ~result[XLEN-1]; registered with result.
REQ-027 in_valid while busy SHALL be ignored (in_ready low); the requester holds it.

Reset
REQ-028 rst SHALL, at the next rising edge, force IDLE, in_ready=1, out_valid=0, result=0, zero=1, lt=0, ge=1, overflow=0, and clear iteration counter/partials.
REQ-029 rst asserted mid-CALC or in DONE SHALL abort the operation; no out_valid for it after reset.
REQ-030 rst SHALL take priority over a simultaneous handshake.

Verification
REQ-031 XLEN=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> 1 cycle later result=0x80000000, overflow=1, lt=1.
REQ-032 MULHU a=b=0xFFFFFFFF -> out_valid after 33 cycles, result=0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-033 DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF in 1 cycle; REM a=0x80000000 b=-1 -> 0.
REQ-034 SRA a=0x80000000 b=0x24 (shift 4) -> 0xF8000000; SLTU a=1 b=0xFFFFFFFF -> 1, zero=0.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid -> result stable, in_ready=0; release -> IDLE next cycle.
REQ-036 Assert rst at CALC cycle 10 of DIV -> next cycle IDLE, out_valid=0, result=0; new ADD 2+3 then returns 5.
